// File: rtl/uart_pkg.sv
// Shared UART types and helpers: receiver state encoding, bit-period math, synchronizer depth.
// Purely declarative; no latency or backpressure of its own.
package uart_pkg;

  localparam int UART_SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_t;

  function automatic int ticks_per_bit(input int clock_freq, input int baud_rate);
    return clock_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Serial line synchronizer with falling-edge detect; UART_SYNC_STAGES cycles of latency.
// No backpressure: free-running every cycle; resets to idle-high so reset never looks like an edge.
module uart_rx_sync
  import uart_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic signal,
  output logic sync_q,
  output logic fall
);

  logic [UART_SYNC_STAGES-1:0] chain_q, chain_d;
  logic                        prev_q, prev_d;

  always_comb begin
    chain_d = {chain_q[UART_SYNC_STAGES-2:0], signal};
    prev_d  = chain_q[UART_SYNC_STAGES-1];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      chain_q <= '1;
      prev_q  <= 1'b1;
    end else begin
      chain_q <= chain_d;
      prev_q  <= prev_d;
    end
  end

  assign sync_q = chain_q[UART_SYNC_STAGES-1];
  assign fall   = prev_q & ~sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver (start, WIDTH data LSB-first, stop); valid rises ~2+T/2+(WIDTH+1)*T cycles after the start edge.
// Held valid/ack output; a word finishing while valid is unconsumed is dropped with an overrun pulse. UART_RX_MAJORITY_VOTE_EN: 2-of-3 sampling.
module uart_rx
  import uart_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int BAUD_RATE  = 9600,
  parameter int CLOCK_FREQ = 460800
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             signal,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  input  logic             ack,
  output logic             busy,
  output logic             framing_error,
  output logic             overrun
);

  localparam int TICKS_PER_BIT = ticks_per_bit(CLOCK_FREQ, BAUD_RATE);
  localparam int TICK_W        = $clog2(TICKS_PER_BIT);
  localparam int IDX_W         = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [TICK_W-1:0] HALF_LOAD = TICK_W'(TICKS_PER_BIT / 2 - 1);
  localparam logic [TICK_W-1:0] FULL_LOAD = TICK_W'(TICKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(WIDTH - 1);

  rx_state_t         state_q, state_d;
  logic [TICK_W-1:0] tick_q, tick_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [WIDTH-1:0]  shift_q, shift_d;
  logic [WIDTH-1:0]  data_q, data_d;
  logic              valid_q, valid_d;
  logic              fe_q, fe_d;
  logic              ov_q, ov_d;
  logic              sync_q, fall, sample, tick_zero;

  uart_rx_sync u_sync (
    .clock  (clock),
    .reset  (reset),
    .signal (signal),
    .sync_q (sync_q),
    .fall   (fall)
  );

`ifdef UART_RX_MAJORITY_VOTE_EN
  // The two previous sync_q values plus the current one form the 3-sample voting window.
  logic [1:0] hist_q, hist_d;
  logic [2:0] window;

  always_comb begin
    hist_d = {hist_q[0], sync_q};
    window = {hist_q, sync_q};
    sample = (window[0] & window[1]) | (window[0] & window[2]) | (window[1] & window[2]);
  end

  always_ff @(posedge clock) begin
    if (reset) hist_q <= '1;
    else       hist_q <= hist_d;
  end
`else
  assign sample = sync_q;
`endif

  always_comb begin
    state_d   = state_q;
    tick_d    = tick_q;
    idx_d     = idx_q;
    shift_d   = shift_q;
    data_d    = data_q;
    valid_d   = valid_q;
    fe_d      = 1'b0;
    ov_d      = 1'b0;
    tick_zero = (tick_q == '0);

    if (valid_q && ack) valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (fall) begin
          tick_d  = HALF_LOAD;
          state_d = START;
        end
      end
      START: begin
        if (!tick_zero) begin
          tick_d = tick_q - TICK_W'(1);
        end else if (!sample) begin
          tick_d  = FULL_LOAD;
          idx_d   = '0;
          state_d = DATA;
        end else begin
          state_d = IDLE;
        end
      end
      DATA: begin
        if (!tick_zero) begin
          tick_d = tick_q - TICK_W'(1);
        end else begin
          shift_d[idx_q] = sample;
          tick_d         = FULL_LOAD;
          if (idx_q == LAST_IDX) state_d = STOP;
          else                   idx_d   = idx_q + IDX_W'(1);
        end
      end
      STOP: begin
        if (!tick_zero) begin
          tick_d = tick_q - TICK_W'(1);
        end else begin
          state_d = IDLE;
          // A same-cycle ack frees the holding slot, so the new word lands without overrun.
          if (!sample) begin
            fe_d = 1'b1;
          end else if (!valid_q || ack) begin
            data_d  = shift_q;
            valid_d = 1'b1;
          end else begin
            ov_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      tick_q  <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      fe_q    <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      fe_q    <= fe_d;
      ov_q    <= ov_d;
    end
  end

  assign data          = data_q;
  assign valid         = valid_q;
  assign busy          = (state_q != IDLE);
  assign framing_error = fe_q;
  assign overrun       = ov_q;

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial receiver for the buffered UART; the downstream counterpart of uart_tx.
- Consumes the idle-high, LSB-first, 8N1-style line that uart_tx drives: start bit 0, WIDTH data bits, one stop bit 1.
- Samples the line at mid-bit and presents each received word on a held valid/ack interface to the RX buffer.
- Reports framing and overrun errors as single-cycle pulses.

Parameters:
- WIDTH, 8, data bits per word.
- BAUD_RATE, 9600, line bit rate in bit/s.
- CLOCK_FREQ, 460800, clock frequency in Hz.
- TICKS_PER_BIT (localparam), CLOCK_FREQ/BAUD_RATE (48 at defaults), clock cycles per bit; must be at least 4.

Ports:
- clock  input  1  single system clock; all logic on rising edge.
- reset  input  1  synchronous reset, active-high.
- signal  input  1  asynchronous serial line, idle high.
- data  output  WIDTH  last received word, LSB = first data bit.
- valid  output  1  data holds an unconsumed word.
- ack  input  1  consumer takes data; effective only while valid=1.
- busy  output  1  a frame is in progress (state != IDLE).
- framing_error  output  1  one-cycle pulse: stop bit sampled 0.
- overrun  output  1  one-cycle pulse: word completed while valid=1.

Behaviour:
- Reset values: data=0, valid=0, busy=0, framing_error=0, overrun=0, state=IDLE, counters=0, synchronizer flops=1.
- Reset mid-frame aborts the frame with no output.
- Synchronizer: signal passes two flops (sync_q). A falling edge is sync_q=0 while the previous sync_q=1.
- IDLE:
  - A falling edge loads tick_cnt=TICKS_PER_BIT/2-1 and moves to START.
  - A line held low never re-triggers.
- START:
  - Counts down to 0, then samples sync_q.
  - Sample 0: load tick_cnt=TICKS_PER_BIT-1, bit_idx=0, go to DATA.
  - Sample 1: glitch; return to IDLE silently.
- DATA:
  - Counts down; at 0, shifts sample into bit position bit_idx and reloads tick_cnt.
  - After bit WIDTH-1, goes to STOP.
- STOP:
  - Counts down; at 0, samples the stop bit and returns to IDLE.
  - Sample 1 with valid=0: data=shift register, valid=1.
  - Sample 1 with valid=1: overrun pulses; data and valid unchanged; new word dropped.
  - Sample 0: framing_error pulses; no data update. IDLE needs a fresh 1→0 edge, so a break condition produces exactly one error.
- Handshake:
  - valid falls on the cycle after ack=1 is seen with valid=1.
  - ack with valid=0 is ignored.
  - ack and a new word completing in the same cycle: new word loads and valid stays 1; no overrun.
- Latency: valid rises 2 + TICKS_PER_BIT/2 + (WIDTH+1)*TICKS_PER_BIT cycles after the line falling edge, ±1 (458 at defaults).
- Line timing: mid-bit sampling tolerates ±TICKS_PER_BIT/4 cumulative drift.
- Back-to-back frames (stop bit immediately followed by a start bit) are received without loss.

Optional Feature:
- Macro UART_RX_MAJORITY_VOTE_EN.
- Defined:
  - Each sample point (start check, data bits, stop bit) uses the 2-of-3 majority of sync_q at counter values 1, 0 and the preceding cycle's value.
  - Implemented as a 3-bit history shift register.
  - Latency unchanged.
  - Rejects single-cycle glitches at the sample point.
- Undefined: single sample of sync_q at tick_cnt=0; no history register.

Decomposition:
- uart_pkg holds:
  - the rx_state_t enum {IDLE, START, DATA, STOP};
  - function ticks_per_bit(clock_freq, baud_rate), shared with uart_tx;
  - the constant UART_SYNC_STAGES=2.
- Sub-module uart_rx_sync: two-flop synchronizer plus falling-edge detect. Outputs sync_q and fall; reset value 1/0.

Test Plan:
- Idle line after reset, 200 cycles → valid=0, busy=0, no error pulses.
- uart_tx at defaults sends 0xA5, then 0x00, then 0xFF → each word appears on data with valid at 458±1 cycles after its start edge; ack clears valid next cycle.
- A 10-cycle low glitch on an idle line → START rejects it; busy returns to 0 within 25 cycles; no valid, no framing_error.
- Frame 0x3C with the stop bit forced 0 for 48 cycles → one framing_error pulse; valid stays 0; next frame 0x3D is received correctly.
- Words 0x11 then 0x22 back-to-back, ack never asserted → data=0x11, valid=1, one overrun pulse at the second stop sample. Ack asserted in the stop-sample cycle instead → data=0x22, no overrun.
- Reset asserted for 1 cycle mid-DATA of 0x5A → all outputs return to reset values; next frame 0x6B is received. With UART_RX_MAJORITY_VOTE_EN defined, a 1-cycle inversion exactly at the bit-3 sample point leaves 0x6B intact.
